pixel_stream_framer: RTL and testbench
======================================

Name: pixel_stream_framer

Overview:
- Downstream consumer of the camera receive top level's parallel pixel output (PAR_RAW, pixel strobe, H_SYNC, V_SYNC).
- Converts sync-delimited raw pixels into a valid/ready stream with start-of-frame and end-of-line tags.
- Checks line length and line count against the sensor geometry.
- Absorbs downstream back-pressure in a small FIFO and flags overflow.

Parameters:
- D_WIDTH, 10, pixel width in bits.
- C_COLUMNS, 320, expected pixels per line.
- C_ROWS, 320, expected lines per frame.
- FIFO_AW, 4, FIFO address width; depth is 2^FIFO_AW entries of D_WIDTH+2 bits.

Ports:
- CLOCK  in  1  system/sample clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PIX_DATA  in  D_WIDTH  raw pixel value.
- PIX_EN  in  1  one-cycle pixel strobe, already synchronous to CLOCK.
- H_SYNC  in  1  active-high line-valid level.
- V_SYNC  in  1  active-high frame-valid level.
- OUT_DATA  out  D_WIDTH  pixel at FIFO head.
- OUT_SOF  out  1  head pixel is first pixel of frame.
- OUT_EOL  out  1  head pixel is last pixel of its line.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts head when OUT_VALID & OUT_READY.
- LINE_ERR  out  1  one-cycle pulse: line ended with pixel count != C_COLUMNS.
- FRAME_OK  out  1  one-cycle pulse: frame ended clean.
- FRAME_ERR  out  1  one-cycle pulse: frame ended with any error.
- OVERFLOW  out  1  sticky; set on write to full FIFO, cleared at next V_SYNC rise.

Behaviour:
- Reset (RESET low, async): all outputs 0, FIFO empty, counters 0, hold register empty, state IDLE.
- Edge detect: registered copies of H_SYNC/V_SYNC; rise and fall are decoded one cycle after the input changes.
- Pixel accepted iff PIX_EN & H_SYNC & V_SYNC in the same cycle; PIX_EN outside that window is ignored.
- FSM states:
  - IDLE -> FRAME on V_SYNC rise. On entry: clear col/row counters, error flag and OVERFLOW; arm SOF.
  - FRAME -> FRAME_END on V_SYNC fall.
  - FRAME_END -> IDLE after one cycle; pulses FRAME_OK or FRAME_ERR.
  - A V_SYNC rise seen in FRAME_END is honoured directly (-> FRAME).
- One-pixel hold register (needed to tag EOL):
  - Accepted pixel goes into the hold register.
  - If the hold register was already full, its old content is pushed first with EOL=0.
  - On H_SYNC fall with the hold register full: push the held pixel with EOL=1, empty the register.
  - SOF is attached to the first accepted pixel after V_SYNC rise.
  - Latency from PIX_EN to OUT_VALID: one cycle after the next accepted pixel, or 2 cycles after H_SYNC goes low.
- Column counter: width clog2(C_COLUMNS+1); increments per accepted pixel, saturates at all-ones.
  - On H_SYNC fall (in FRAME): if count != C_COLUMNS, pulse LINE_ERR and set the frame error flag.
  - Then increment the row counter (saturating) and clear the column counter.
- V_SYNC and H_SYNC fall on the same cycle: line-end processing (flush, LINE_ERR check, row increment) happens first. The frame check uses the updated row count in FRAME_END.
- Frame check: row count != C_ROWS, any LINE_ERR, or any overflow -> FRAME_ERR; else FRAME_OK.
- H_SYNC fall outside FRAME: ignored.
- FIFO:
  - Push and pop are allowed in the same cycle, including when full: pop frees the slot, so no overflow.
  - Push when full with no pop: word dropped, OVERFLOW set, frame error flag set.
  - OUT_* is driven from registered head data (first-word fall-through); OUT_VALID = not empty.
  - Pointers are FIFO_AW+1 bits; full/empty are decided by MSB comparison; wrap-around is natural.
- Reset mid-frame: immediate return to IDLE, FIFO flushed. A frame already in progress when reset releases (V_SYNC high) is not captured until the next V_SYNC rise.

Decomposition:
- Shared package (video_pkg):
  - FSM state enum (IDLE, FRAME, FRAME_END).
  - Tag field positions: SOF = bit D_WIDTH+1, EOL = bit D_WIDTH.
  - Default geometry constants 320x320.
- One sub-module, sync_fifo (parameters DW, AW):
  - Ports: CLOCK, RESET, WR_EN, WR_DATA, RD_EN, RD_DATA, EMPTY, FULL.
  - Framer instantiates it with DW = D_WIDTH+2.

Test Plan:
- C_COLUMNS=4, C_ROWS=2, OUT_READY=1; two lines of pixels 1..4 and 5..8 -> 8 outputs in order; SOF only on 1; EOL on 4 and 8; one FRAME_OK; no LINE_ERR.
- Line of 3 pixels in a 4-column frame -> LINE_ERR pulse at that line end; FRAME_ERR, no FRAME_OK.
- Three lines in a 2-row frame -> no LINE_ERR; FRAME_ERR at frame end.
- FIFO_AW=2, OUT_READY=0, 6 pixels -> 4 stored, OVERFLOW=1, FRAME_ERR. Next V_SYNC rise clears OVERFLOW; draining outputs the first 4 pixels intact.
- V_SYNC and H_SYNC fall on the same cycle after pixel 4 -> pixel 4 emitted with EOL=1; row count 2; FRAME_OK.
- RESET low mid-line with FIFO non-empty -> OUT_VALID=0 immediately. After release, pixels before the next V_SYNC rise are ignored.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the pixel stream path: framer FSM encoding,
// tag bit positions in the stored FIFO word, and default sensor geometry.
package video_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FRAME     = 2'd1;
   localparam logic [1:0] ST_FRAME_END = 2'd2;

   localparam int DEF_COLUMNS = 320;
   localparam int DEF_ROWS    = 320;

   // Stored word layout: {SOF, EOL, pixel[dw-1:0]}
   function automatic int sof_pos(input int dw);
      return dw + 1;
   endfunction

   function automatic int eol_pos(input int dw);
      return dw;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; RD_DATA always shows the head entry.
module sync_fifo #(
   parameter int DW = 12,
   parameter int AW = 4
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          WR_EN,
   input  logic [DW-1:0] WR_DATA,
   input  logic          RD_EN,
   output logic [DW-1:0] RD_DATA,
   output logic          EMPTY,
   output logic          FULL
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign EMPTY   = (wr_ptr == rd_ptr);
   assign FULL    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = RD_EN & ~EMPTY;
   // A simultaneous read frees the slot, so a full FIFO can still accept.
   assign do_wr   = WR_EN & (~FULL | do_rd);
   assign RD_DATA = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= WR_DATA;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/pixel_stream_framer.sv
// Turns sync-delimited camera pixels into a SOF/EOL-tagged valid/ready stream,
// checking line length and line count and flagging FIFO overflow.
module pixel_stream_framer
   import video_pkg::*;
#(
   parameter int D_WIDTH   = 10,
   parameter int C_COLUMNS = DEF_COLUMNS,
   parameter int C_ROWS    = DEF_ROWS,
   parameter int FIFO_AW   = 4
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic [D_WIDTH-1:0] PIX_DATA,
   input  logic               PIX_EN,
   input  logic               H_SYNC,
   input  logic               V_SYNC,
   output logic [D_WIDTH-1:0] OUT_DATA,
   output logic               OUT_SOF,
   output logic               OUT_EOL,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic               LINE_ERR,
   output logic               FRAME_OK,
   output logic               FRAME_ERR,
   output logic               OVERFLOW
);

   localparam int CW    = $clog2(C_COLUMNS + 1);
   localparam int RW    = $clog2(C_ROWS + 1);
   localparam int TW    = D_WIDTH + 2;
   localparam int SOF_B = sof_pos(D_WIDTH);
   localparam int EOL_B = eol_pos(D_WIDTH);
   localparam logic [CW-1:0] COL_EXP = CW'(C_COLUMNS);
   localparam logic [RW-1:0] ROW_EXP = RW'(C_ROWS);

   logic [1:0]         state;
   logic               h_q1, h_q2, v_q1, v_q2;
   logic               h_fall, v_rise, v_fall;
   logic               in_frame, accept, line_end, flush, entering;
   logic               push, pop, ovf_evt, frame_bad;
   logic               hold_vld, hold_sof, sof_arm, err_flag;
   logic [D_WIDTH-1:0] hold_data;
   logic [CW-1:0]      col_cnt;
   logic [RW-1:0]      row_cnt;
   logic [TW-1:0]      push_data;
   logic [TW-1:0]      head;
   logic               fifo_empty, fifo_full;

   assign h_fall    = h_q2 & ~h_q1;
   assign v_rise    = v_q1 & ~v_q2;
   assign v_fall    = v_q2 & ~v_q1;
   assign in_frame  = (state == ST_FRAME);
   assign entering  = v_rise & (state != ST_FRAME);
   assign accept    = PIX_EN & H_SYNC & V_SYNC & in_frame;
   assign line_end  = in_frame & h_fall;
   assign flush     = line_end & hold_vld;
   assign push      = flush | (accept & hold_vld);
   assign pop       = OUT_READY & ~fifo_empty;
   assign ovf_evt   = push & fifo_full & ~pop;
   assign frame_bad = err_flag | (row_cnt != ROW_EXP) | OVERFLOW;

   always_comb begin
      push_data                = '0;
      push_data[D_WIDTH-1:0]   = hold_data;
      push_data[EOL_B]         = flush;
      push_data[SOF_B]         = hold_sof;
   end

   // V_SYNC copies reset high so a frame already running at reset release
   // never decodes as a rise; only the next genuine rise starts capture.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         h_q1 <= 1'b0;
         h_q2 <= 1'b0;
         v_q1 <= 1'b1;
         v_q2 <= 1'b1;
      end else begin
         h_q1 <= H_SYNC;
         h_q2 <= h_q1;
         v_q1 <= V_SYNC;
         v_q2 <= v_q1;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (v_rise) state <= ST_FRAME;
            ST_FRAME:     if (v_fall) state <= ST_FRAME_END;
            ST_FRAME_END: state <= v_rise ? ST_FRAME : ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         hold_vld  <= 1'b0;
         hold_sof  <= 1'b0;
         hold_data <= '0;
         sof_arm   <= 1'b0;
      end else begin
         if (accept) begin
            hold_vld  <= 1'b1;
            hold_sof  <= sof_arm;
            hold_data <= PIX_DATA;
         end else if (flush) begin
            hold_vld  <= 1'b0;
         end
         if (entering)    sof_arm <= 1'b1;
         else if (accept) sof_arm <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         err_flag  <= 1'b0;
         OVERFLOW  <= 1'b0;
         LINE_ERR  <= 1'b0;
         FRAME_OK  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         LINE_ERR  <= line_end & (col_cnt != COL_EXP);
         FRAME_OK  <= (state == ST_FRAME_END) & ~frame_bad;
         FRAME_ERR <= (state == ST_FRAME_END) & frame_bad;
         if (entering) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            err_flag <= 1'b0;
            OVERFLOW <= 1'b0;
         end else begin
            // A pixel landing on the line-end cycle belongs to the next line.
            if (line_end)                    col_cnt <= accept ? CW'(1) : '0;
            else if (accept && col_cnt != '1) col_cnt <= col_cnt + 1'b1;
            if (line_end && row_cnt != '1)   row_cnt <= row_cnt + 1'b1;
            if ((line_end && col_cnt != COL_EXP) || ovf_evt) err_flag <= 1'b1;
            if (ovf_evt)                     OVERFLOW <= 1'b1;
         end
      end
   end

   sync_fifo #(.DW(TW), .AW(FIFO_AW)) u_fifo (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .WR_EN   (push),
      .WR_DATA (push_data),
      .RD_EN   (pop),
      .RD_DATA (head),
      .EMPTY   (fifo_empty),
      .FULL    (fifo_full)
   );

   assign OUT_VALID = ~fifo_empty;
   assign OUT_DATA  = head[D_WIDTH-1:0];
   assign OUT_EOL   = head[EOL_B];
   assign OUT_SOF   = head[SOF_B];

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed bench for pixel_stream_framer on a 4x2 geometry with a 4-deep FIFO.
module tb_pixel_stream_framer;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic [9:0] PIX_DATA = '0;
   logic       PIX_EN = 1'b0;
   logic       H_SYNC = 1'b0;
   logic       V_SYNC = 1'b0;
   logic       OUT_READY = 1'b1;
   logic [9:0] OUT_DATA;
   logic       OUT_SOF, OUT_EOL, OUT_VALID;
   logic       LINE_ERR, FRAME_OK, FRAME_ERR, OVERFLOW;

   pixel_stream_framer #(.D_WIDTH(10), .C_COLUMNS(4), .C_ROWS(2), .FIFO_AW(2)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .PIX_DATA  (PIX_DATA),
      .PIX_EN    (PIX_EN),
      .H_SYNC    (H_SYNC),
      .V_SYNC    (V_SYNC),
      .OUT_DATA  (OUT_DATA),
      .OUT_SOF   (OUT_SOF),
      .OUT_EOL   (OUT_EOL),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .LINE_ERR  (LINE_ERR),
      .FRAME_OK  (FRAME_OK),
      .FRAME_ERR (FRAME_ERR),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int   pix;
      logic sof;
      logic eol;
   } vec_t;

   vec_t        tbl[$];
   logic [11:0] got[$];
   int          n_le = 0, n_ok = 0, n_er = 0;
   int          n_chk = 0, n_fail = 0;

   // Monitor: every accepted output word and every status pulse.
   always @(negedge CLOCK) begin
      if (LINE_ERR)  n_le++;
      if (FRAME_OK)  n_ok++;
      if (FRAME_ERR) n_er++;
      if (OUT_VALID && OUT_READY) got.push_back({OUT_SOF, OUT_EOL, OUT_DATA});
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic add(input int p, input logic s, input logic e);
      vec_t v;
      v.pix = p; v.sof = s; v.eol = e;
      tbl.push_back(v);
   endtask

   task automatic pix(input int p);
      PIX_DATA = 10'(p);
      PIX_EN   = 1'b1;
      cyc(1);
      PIX_EN   = 1'b0;
      cyc(1);
   endtask

   task automatic send_line(input int first, input int n);
      H_SYNC = 1'b1;
      cyc(1);
      for (int i = 0; i < n; i++) pix(first + i);
      H_SYNC = 1'b0;
      cyc(3);
   endtask

   task automatic frame_start();
      V_SYNC = 1'b1;
      cyc(3);
   endtask

   task automatic frame_end();
      V_SYNC = 1'b0;
      cyc(5);
   endtask

   int le0, ok0, er0;

   task automatic snap();
      le0 = n_le; ok0 = n_ok; er0 = n_er;
   endtask

   task automatic chk_counts(input string tag, input int le, input int ok, input int er);
      chk({tag, "_line_err"},  n_le - le0, le);
      chk({tag, "_frame_ok"},  n_ok - ok0, ok);
      chk({tag, "_frame_err"}, n_er - er0, er);
   endtask

   initial begin
      // Expected output stream, in order, across the whole run.
      add(1, 1, 0);  add(2, 0, 0);  add(3, 0, 0);  add(4, 0, 1);
      add(5, 0, 0);  add(6, 0, 0);  add(7, 0, 0);  add(8, 0, 1);
      add(11, 1, 0); add(12, 0, 0); add(13, 0, 0); add(14, 0, 1);
      add(21, 0, 0); add(22, 0, 0); add(23, 0, 1);
      add(71, 1, 0); add(72, 0, 0); add(73, 0, 0); add(74, 0, 1);
      add(75, 0, 0); add(76, 0, 0); add(77, 0, 0); add(78, 0, 1);
      add(81, 0, 0); add(82, 0, 0); add(83, 0, 0); add(84, 0, 1);
      add(31, 1, 0); add(32, 0, 0); add(33, 0, 0); add(34, 0, 0);
      add(41, 1, 0); add(42, 0, 0); add(43, 0, 0); add(44, 0, 1);
      add(45, 0, 0); add(46, 0, 0); add(47, 0, 0); add(48, 0, 1);
      add(61, 1, 0); add(62, 0, 0); add(63, 0, 0); add(64, 0, 1);
      add(65, 0, 0); add(66, 0, 0); add(67, 0, 0); add(68, 0, 1);

      // Reset state
      cyc(2);
      chk("rst_out_valid", int'(OUT_VALID), 0);
      chk("rst_out_data",  int'(OUT_DATA), 0);
      chk("rst_out_sof",   int'(OUT_SOF), 0);
      chk("rst_out_eol",   int'(OUT_EOL), 0);
      chk("rst_line_err",  int'(LINE_ERR), 0);
      chk("rst_frame_ok",  int'(FRAME_OK), 0);
      chk("rst_frame_err", int'(FRAME_ERR), 0);
      chk("rst_overflow",  int'(OVERFLOW), 0);
      RESET = 1'b1;
      cyc(2);

      // Clean 4x2 frame
      snap();
      frame_start();
      send_line(1, 4);
      send_line(5, 4);
      frame_end();
      chk_counts("clean", 0, 1, 0);

      // Short second line
      snap();
      frame_start();
      send_line(11, 4);
      send_line(21, 3);
      frame_end();
      chk_counts("short", 1, 0, 1);

      // Too many lines
      snap();
      frame_start();
      send_line(71, 4);
      send_line(75, 4);
      send_line(81, 4);
      frame_end();
      chk_counts("rows", 0, 0, 1);

      // Overflow with a stalled consumer
      OUT_READY = 1'b0;
      snap();
      frame_start();
      send_line(31, 6);
      chk("ovf_set", int'(OVERFLOW), 1);
      frame_end();
      chk("ovf_frame_err", n_er - er0, 1);
      chk("ovf_frame_ok",  n_ok - ok0, 0);
      chk("ovf_sticky",    int'(OVERFLOW), 1);
      frame_start();
      chk("ovf_cleared", int'(OVERFLOW), 0);
      chk("ovf_held_valid", int'(OUT_VALID), 1);
      OUT_READY = 1'b1;
      cyc(6);
      chk("ovf_drained", int'(OUT_VALID), 0);
      frame_end();

      // H_SYNC and V_SYNC fall together on the last line
      snap();
      frame_start();
      H_SYNC = 1'b1;
      cyc(1);
      pix(41);
      chk("hold_not_visible", int'(OUT_VALID), 0);
      for (int i = 42; i <= 44; i++) pix(i);
      H_SYNC = 1'b0;
      cyc(3);
      H_SYNC = 1'b1;
      cyc(1);
      for (int i = 45; i <= 48; i++) pix(i);
      H_SYNC = 1'b0;
      V_SYNC = 1'b0;
      cyc(6);
      chk_counts("samefall", 0, 1, 0);

      // Reset in mid-line with data queued
      OUT_READY = 1'b0;
      frame_start();
      H_SYNC = 1'b1;
      cyc(1);
      pix(51); pix(52); pix(53);
      chk("pre_rst_valid", int'(OUT_VALID), 1);
      RESET = 1'b0;
      #1;
      chk("async_rst_valid", int'(OUT_VALID), 0);
      cyc(2);
      RESET = 1'b1;
      cyc(1);
      pix(54); pix(55);
      H_SYNC = 1'b0;
      cyc(3);
      V_SYNC = 1'b0;
      OUT_READY = 1'b1;
      cyc(5);
      chk("post_rst_ignored", int'(OUT_VALID), 0);
      snap();
      frame_start();
      send_line(61, 4);
      send_line(65, 4);
      frame_end();
      chk_counts("after_rst", 0, 1, 0);

      // Output stream against the table
      chk("pop_count", got.size(), tbl.size());
      for (int i = 0; i < tbl.size(); i++) begin
         if (i < got.size())
            chk($sformatf("word%0d", i), int'(got[i]),
                int'({tbl[i].sof, tbl[i].eol, 10'(tbl[i].pix)}));
         else
            chk($sformatf("word%0d_missing", i), 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule
